hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter REG_W, default 5, register-index width.
REQ-002 Parameter CNT_W, default 32, performance-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 Rs1D, Rs2D  in  REG_W each  source registers of the instruction in Decode.
REQ-006 Rs1E, Rs2E, RdE  in  REG_W each  source and destination registers in Execute.
REQ-007 RdM, RdW  in  REG_W each  destination registers in Memory and Writeback.
REQ-008 RegWriteM, RegWriteW  in  1 each  register-write enables of the M and W stages.
REQ-009 LoadE  in  1  the instruction in Execute is a load.
REQ-010 PCSrcE  in  1  branch or jump taken, resolved in Execute.
REQ-011 MemReqM, MemReadyM  in  1 each  data-memory access in M; memory ready.
REQ-012 ForwardAE, ForwardBE  out  2 each  ALU operand source select.
REQ-013 StallF, StallD, StallE, StallM, StallW  out  1 each  hold the corresponding pipeline register.
REQ-014 FlushD, FlushE  out  1 each  clear the ID/EX pipeline registers to a bubble.
REQ-015 StallCount, FlushCount  out  CNT_W each  performance counters, present only with HAZARD_PERF_EN.

Function
REQ-016 Forwarding (combinational, in every state) SHALL select the operand source as follows:
- FWD_MEM (10) when RegWriteM, RdM != 0 and RdM == Rs1E (or Rs2E);
- else FWD_WB (01) when RegWriteW, RdW != 0 and RdW == Rs1E (or Rs2E);
- else FWD_RF (00).
- M takes priority over W.
REQ-017 lwStall SHALL be LoadE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D).
REQ-018 The FSM SHALL have three states, INIT, RUN and MEM_WAIT, and outputs SHALL be a function of state and inputs (Mealy).
REQ-019 In INIT: FlushD = FlushE = StallF = 1; all other stall outputs = 0; next state is RUN unconditionally.
REQ-020 In RUN with no memory wait:
- StallF = StallD = lwStall;
- FlushD = PCSrcE;
- FlushE = lwStall | PCSrcE;
- StallE = StallM = StallW = 0.
REQ-021 RUN SHALL go to MEM_WAIT when MemReqM & !MemReadyM; in that same cycle all five stalls = 1 and FlushD = FlushE = 0 (memory stall overrides lwStall and PCSrcE).
REQ-022 In MEM_WAIT: all five stalls = 1 and no flushes; it returns to RUN on the first cycle that MemReadyM = 1, and that cycle's outputs follow RUN rules (REQ-020).
REQ-023 Because the pipeline is frozen, a PCSrcE or lwStall condition that arrives during a memory stall SHALL be acted on in the first non-stalled cycle; no event is lost or applied twice.
REQ-024 A branch and a load-use stall in the same cycle SHALL give StallF = StallD = 1, FlushD = FlushE = 1.
REQ-025 Latency: zero cycles; stall and flush outputs are valid in the same cycle as their causing inputs.

Reset
REQ-026 While reset_n = 0 at a clock edge, the state SHALL become INIT and the counters SHALL become 0.
REQ-027 While in INIT, including the reset cycle, outputs SHALL follow REQ-019 and the forwarding outputs SHALL be 00.
REQ-028 Asserting reset mid-MEM_WAIT SHALL abandon the wait with no residual stall after the INIT cycle.

Configuration
REQ-029 With HAZARD_PERF_EN defined:
- StallCount increments in every cycle StallD = 1;
- FlushCount increments in every cycle FlushE = 1;
- both saturate at all-ones and do not wrap.
REQ-030 Without HAZARD_PERF_EN, the counter ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Package riscv_pkg SHALL hold the hazard_state_t enum (INIT, RUN, MEM_WAIT) and the constants FWD_RF, FWD_WB and FWD_MEM.
REQ-032 Sub-module hazard_forward (combinational, one operand) SHALL be instantiated twice, for A and B.

Verification
REQ-033 Reset release: hold reset_n = 0 for 2 cycles, then 1 -> one cycle with FlushD = FlushE = StallF = 1, then RUN with all controls 0.
REQ-034 Forwarding: RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, Rs1E = 5 -> ForwardAE = 10; clear RegWriteM -> 01; set RdM = RdW = 0 -> 00.
REQ-035 Load-use: LoadE = 1, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for exactly one cycle; FlushD = 0.
REQ-036 Branch during load-use: PCSrcE = 1 together with REQ-035 inputs -> FlushD = FlushE = StallF = StallD = 1.
REQ-037 Memory wait: MemReqM = 1, MemReadyM = 0 for 3 cycles with PCSrcE = 1 -> all stalls = 1 and no flush for 3 cycles; on MemReadyM = 1 -> FlushD = FlushE = 1 and stalls clear.
REQ-038 HAZARD_PERF_EN with CNT_W = 4: force 20 stall cycles -> StallCount saturates at 15; reset_n = 0 -> 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package riscv_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_if.sv
// Pipeline-to-hazard-unit signal bundle. The performance counters exist only
// when HAZARD_PERF_EN is defined.
interface hazard_if #(
    parameter int REG_W = 5
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
);

    logic [REG_W-1:0] Rs1D;
    logic [REG_W-1:0] Rs2D;
    logic [REG_W-1:0] Rs1E;
    logic [REG_W-1:0] Rs2E;
    logic [REG_W-1:0] RdE;
    logic [REG_W-1:0] RdM;
    logic [REG_W-1:0] RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             LoadE;
    logic             PCSrcE;
    logic             MemReqM;
    logic             MemReadyM;

    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             StallW;
    logic             FlushD;
    logic             FlushE;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;
`endif

    // Pipeline side: drives register indices and stage status.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE
`ifdef HAZARD_PERF_EN
        ,
        input  StallCount, FlushCount
`endif
    );

    // Hazard unit side.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE
`ifdef HAZARD_PERF_EN
        ,
        output StallCount, FlushCount
`endif
    );

endinterface

// File: rtl/hazard_forward.sv
// Operand forwarding select for one ALU source operand.
module hazard_forward
    import riscv_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    output logic [1:0]       fwd
);

    // M holds the newer result, so it wins over W; x0 is never forwarded.
    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            fwd = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush and
// memory-wait freeze. Optional saturating stall/flush performance counters
// are built when HAZARD_PERF_EN is defined.
//
// state    | meaning
// INIT     | first cycle after reset: flush D/E, hold fetch
// RUN      | normal operation, load-use stall and branch flush
// MEM_WAIT | data memory busy: whole pipeline frozen, no flushes
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input logic   clk,
    input logic   reset_n,
    hazard_if.slave hz
);

    hazard_state_t state;
    hazard_state_t state_cur;
    hazard_state_t state_nxt;

    logic       lw_stall;
    logic       mem_stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    logic stall_f, stall_d, stall_e, stall_m, stall_w;
    logic flush_d, flush_e;

    hazard_forward #(.REG_W(REG_W)) u_fwd_a (
        .rs          (hz.Rs1E),
        .rd_m        (hz.RdM),
        .rd_w        (hz.RdW),
        .reg_write_m (hz.RegWriteM),
        .reg_write_w (hz.RegWriteW),
        .fwd         (fwd_a)
    );

    hazard_forward #(.REG_W(REG_W)) u_fwd_b (
        .rs          (hz.Rs2E),
        .rd_m        (hz.RdM),
        .rd_w        (hz.RdW),
        .reg_write_m (hz.RegWriteM),
        .reg_write_w (hz.RegWriteW),
        .fwd         (fwd_b)
    );

    // The reset cycle already behaves as INIT, before the register catches up.
    assign state_cur = reset_n ? state : INIT;

    assign lw_stall  = hz.LoadE && (hz.RdE != '0) &&
                       ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    assign mem_stall = hz.MemReqM && !hz.MemReadyM;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Mealy outputs. Inputs are held while frozen, so a
    // branch or load-use seen during a wait is applied once, on release.
    always_comb begin
        state_nxt = state_cur;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        stall_w   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        case (state_cur)
            INIT: begin
                stall_f   = 1'b1;
                flush_d   = 1'b1;
                flush_e   = 1'b1;
                state_nxt = RUN;
            end
            RUN, MEM_WAIT: begin
                if ((state_cur == RUN && mem_stall) ||
                    (state_cur == MEM_WAIT && !hz.MemReadyM)) begin
                    stall_f   = 1'b1;
                    stall_d   = 1'b1;
                    stall_e   = 1'b1;
                    stall_m   = 1'b1;
                    stall_w   = 1'b1;
                    state_nxt = MEM_WAIT;
                end else begin
                    stall_f   = lw_stall;
                    stall_d   = lw_stall;
                    flush_d   = hz.PCSrcE;
                    flush_e   = lw_stall || hz.PCSrcE;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    assign hz.ForwardAE = (state_cur == INIT) ? FWD_RF : fwd_a;
    assign hz.ForwardBE = (state_cur == INIT) ? FWD_RF : fwd_b;
    assign hz.StallF    = stall_f;
    assign hz.StallD    = stall_d;
    assign hz.StallE    = stall_e;
    assign hz.StallM    = stall_m;
    assign hz.StallW    = stall_w;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    // Saturating event counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_d && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (flush_e && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

    assign hz.StallCount = stall_count;
    assign hz.FlushCount = flush_count;
`else
    // Counter width is only meaningful with the counters built; keep it sane.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit. Control vector order used in
// comparisons: {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}.
module tb_hazard_unit;

`ifdef HAZARD_PERF_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif
    localparam int REG_W = 5;

    localparam logic [6:0] C_INIT  = 7'b1000011;
    localparam logic [6:0] C_IDLE  = 7'b0000000;
    localparam logic [6:0] C_LWST  = 7'b1100001;
    localparam logic [6:0] C_BRLW  = 7'b1100011;
    localparam logic [6:0] C_BR    = 7'b0000011;
    localparam logic [6:0] C_FREEZ = 7'b1111100;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    logic [6:0] got;

`ifdef HAZARD_PERF_EN
    hazard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();
`else
    hazard_if #(.REG_W(REG_W)) hz ();
`endif

    hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctrl();
        return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW,
                hz.FlushD, hz.FlushE};
    endfunction

    task automatic clear_inputs();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.LoadE = 1'b0;
        hz.PCSrcE = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.Rs1E = 5'd5;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        got = ctrl();
        checks++;
        if (got !== C_INIT) begin
            $display("FAIL reset_ctrl: got %b expected %b", got, C_INIT); errors++;
        end
        checks++;
        if (hz.ForwardAE !== 2'b00) begin
            $display("FAIL reset_fwd: got %b expected 00", hz.ForwardAE); errors++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        clear_inputs();
        #1;
        got = ctrl();
        checks++;
        if (got !== C_INIT) begin
            $display("FAIL init_cycle: got %b expected %b", got, C_INIT); errors++;
        end
        @(negedge clk);
        #1;
        got = ctrl();
        checks++;
        if (got !== C_IDLE) begin
            $display("FAIL run_idle: got %b expected %b", got, C_IDLE); errors++;
        end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
        hz.Rs1E = 5'd5; hz.Rs2E = 5'd3;
        #1;
        checks++;
        if (hz.ForwardAE !== 2'b10) begin
            $display("FAIL fwd_mem: got %b expected 10", hz.ForwardAE); errors++;
        end
        checks++;
        if (hz.ForwardBE !== 2'b00) begin
            $display("FAIL fwd_b_none: got %b expected 00", hz.ForwardBE); errors++;
        end
        hz.RegWriteM = 1'b0;
        #1;
        checks++;
        if (hz.ForwardAE !== 2'b01) begin
            $display("FAIL fwd_wb: got %b expected 01", hz.ForwardAE); errors++;
        end
        hz.RegWriteM = 1'b1; hz.RdM = '0; hz.RdW = '0; hz.Rs1E = '0;
        #1;
        checks++;
        if (hz.ForwardAE !== 2'b00) begin
            $display("FAIL fwd_x0: got %b expected 00", hz.ForwardAE); errors++;
        end
        hz.RdM = 5'd9; hz.RegWriteM = 1'b0; hz.RdW = 5'd9; hz.Rs2E = 5'd9;
        #1;
        checks++;
        if (hz.ForwardBE !== 2'b01) begin
            $display("FAIL fwd_b_wb: got %b expected 01", hz.ForwardBE); errors++;
        end
        hz.RegWriteM = 1'b1; hz.RdW = 5'd4;
        #1;
        checks++;
        if (hz.ForwardBE !== 2'b10) begin
            $display("FAIL fwd_b_mem: got %b expected 10", hz.ForwardBE); errors++;
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        #1;
        got = ctrl();
        checks++;
        if (got !== C_LWST) begin
            $display("FAIL load_use: got %b expected %b", got, C_LWST); errors++;
        end
        @(negedge clk);
        hz.LoadE = 1'b0; hz.RdE = '0;
        #1;
        got = ctrl();
        checks++;
        if (got !== C_IDLE) begin
            $display("FAIL load_use_once: got %b expected %b", got, C_IDLE); errors++;
        end
        hz.LoadE = 1'b1; hz.RdE = '0; hz.Rs1D = '0;
        #1;
        got = ctrl();
        checks++;
        if (got !== C_IDLE) begin
            $display("FAIL load_x0: got %b expected %b", got, C_IDLE); errors++;
        end
        clear_inputs();
    endtask

    task automatic test_branch_load();
        @(negedge clk);
        hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.PCSrcE = 1'b1;
        #1;
        got = ctrl();
        checks++;
        if (got !== C_BRLW) begin
            $display("FAIL branch_load: got %b expected %b", got, C_BRLW); errors++;
        end
        @(negedge clk);
        hz.LoadE = 1'b0; hz.RdE = '0;
        #1;
        got = ctrl();
        checks++;
        if (got !== C_BR) begin
            $display("FAIL branch_only: got %b expected %b", got, C_BR); errors++;
        end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        @(negedge clk);
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0; hz.PCSrcE = 1'b1;
        hz.RegWriteM = 1'b1; hz.RdM = 5'd6; hz.Rs1E = 5'd6;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            got = ctrl();
            checks++;
            if (got !== C_FREEZ) begin
                $display("FAIL mem_wait_%0d: got %b expected %b", i, got, C_FREEZ); errors++;
            end
        end
        checks++;
        if (hz.ForwardAE !== 2'b10) begin
            $display("FAIL mem_wait_fwd: got %b expected 10", hz.ForwardAE); errors++;
        end
        @(negedge clk);
        hz.MemReadyM = 1'b1;
        #1;
        got = ctrl();
        checks++;
        if (got !== C_BR) begin
            $display("FAIL mem_release_branch: got %b expected %b", got, C_BR); errors++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        got = ctrl();
        checks++;
        if (got !== C_IDLE) begin
            $display("FAIL mem_after: got %b expected %b", got, C_IDLE); errors++;
        end
    endtask

    task automatic test_mem_load_use();
        @(negedge clk);
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
        hz.LoadE = 1'b1; hz.RdE = 5'd12; hz.Rs1D = 5'd12;
        #1;
        got = ctrl();
        checks++;
        if (got !== C_FREEZ) begin
            $display("FAIL mem_lw_freeze: got %b expected %b", got, C_FREEZ); errors++;
        end
        @(negedge clk);
        hz.MemReadyM = 1'b1;
        #1;
        got = ctrl();
        checks++;
        if (got !== C_LWST) begin
            $display("FAIL mem_lw_release: got %b expected %b", got, C_LWST); errors++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        got = ctrl();
        checks++;
        if (got !== C_IDLE) begin
            $display("FAIL mem_lw_after: got %b expected %b", got, C_IDLE); errors++;
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        #1;
        got = ctrl();
        checks++;
        if (got !== C_INIT) begin
            $display("FAIL mid_wait_reset: got %b expected %b", got, C_INIT); errors++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        got = ctrl();
        checks++;
        if (got !== C_INIT) begin
            $display("FAIL mid_wait_init: got %b expected %b", got, C_INIT); errors++;
        end
        @(negedge clk);
        #1;
        got = ctrl();
        checks++;
        if (got !== C_IDLE) begin
            $display("FAIL mid_wait_residual: got %b expected %b", got, C_IDLE); errors++;
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (hz.StallCount !== 4'd0 || hz.FlushCount !== 4'd0) begin
            $display("FAIL perf_reset: got %0d/%0d expected 0/0", hz.StallCount, hz.FlushCount); errors++;
        end
        @(negedge clk);
        hz.LoadE = 1'b1; hz.RdE = 5'd3; hz.Rs1D = 5'd3;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (hz.StallCount !== 4'd10 || hz.FlushCount !== 4'd11) begin
            $display("FAIL perf_count: got %0d/%0d expected 10/11", hz.StallCount, hz.FlushCount); errors++;
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (hz.StallCount !== 4'd15 || hz.FlushCount !== 4'd15) begin
            $display("FAIL perf_saturate: got %0d/%0d expected 15/15", hz.StallCount, hz.FlushCount); errors++;
        end
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (hz.StallCount !== 4'd0 || hz.FlushCount !== 4'd0) begin
            $display("FAIL perf_clear: got %0d/%0d expected 0/0", hz.StallCount, hz.FlushCount); errors++;
        end
        reset_n = 1'b1;
        clear_inputs();
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_load();
        test_mem_wait();
        test_mem_load_use();
        test_reset_mid_wait();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
